vc_packet_tx: RTL

VC_PACKET_TX -- requirements
Module: vc_packet_tx

---
 rtl/vc_packet_tx.sv | 94 +++++++++
 1 files changed

// File: rtl/vc_packet_tx.sv
// vc_packet_tx: drains length-prefixed packets from a VC FIFO onto a valid/ready
// byte link. A packet is started only once header plus full payload are buffered.
module vc_packet_tx #(
  parameter int MAX_PAYLOAD = 30
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] buf_data,
  input  logic       buf_empty,
  input  logic       buf_full,
  input  logic [4:0] buf_ocup,
  output logic       buf_read_en,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic [7:0] tx_data,
  output logic       tx_sop,
  output logic       tx_eop,
  output logic       err_len,
  output logic [7:0] pkt_count
);

  typedef enum logic [1:0] {IDLE, SEND, DROP} state_t;

  localparam logic [5:0] MAX_LEN = 6'(MAX_PAYLOAD);

  state_t     state;
  logic [4:0] rem;
  logic       first;
  logic [4:0] hdr_len;
  logic [5:0] avail;
  logic [5:0] need;
  logic       too_long;
  logic       complete;
  logic       beat;
  logic       in_send;

  // The FIFO reports occupancy 0 when full, so full has to be folded back in as 32.
  assign hdr_len  = buf_data[4:0];
  assign avail    = buf_full ? 6'd32 : {1'b0, buf_ocup};
  assign need     = {1'b0, hdr_len} + 6'd1;
  assign too_long = ({1'b0, hdr_len} > MAX_LEN);
  assign complete = (avail >= need);

  assign in_send     = (state == SEND);
  assign tx_valid    = in_send & ~buf_empty;
  assign tx_data     = tx_valid ? buf_data : 8'd0;
  assign tx_sop      = in_send & first;
  assign tx_eop      = in_send & (rem == 5'd0);
  assign beat        = tx_valid & tx_ready;
  // In DROP the header is still at the FIFO head, so the pop cannot underflow.
  assign buf_read_en = beat | ((state == DROP) & ~buf_empty);
  assign err_len     = (state == DROP);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      rem       <= 5'd0;
      first     <= 1'b0;
      pkt_count <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          if (!buf_empty) begin
            if (too_long) begin
              state <= DROP;
            end else if (complete) begin
              state <= SEND;
              rem   <= hdr_len;
              first <= 1'b1;
            end
          end
        end
        SEND: begin
          if (beat) begin
            first <= 1'b0;
            if (rem == 5'd0) begin
              state     <= IDLE;
              pkt_count <= pkt_count + 8'd1;
            end else begin
              rem <= rem - 5'd1;
            end
          end
        end
        DROP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
